// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter and write sequencer for one shared
// W-bit register. A requester is granted in IDLE, its lane is loaded on the
// GRANT->WRITE edge (if it still requests), then ack pulses for one cycle and
// priority rotates to the requester after the one that wrote.
//
// Handshake: req is a level held until ack (or withdrawn); gnt is registered
// and one-hot or zero; ack is a one-cycle pulse that only ever coincides with
// the matching gnt bit. Dropping req while granted aborts the write.
module reg_share_arbiter #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic           CLK,
   input  logic           CLR,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] wdata,
   output logic [N-1:0]   gnt,
   output logic [N-1:0]   ack,
   output logic [W-1:0]   Q,
   output logic           busy,
   output logic [IW-1:0]  owner
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [IW-1:0] ptr, ptr_nxt;        // first index scanned at next IDLE
   logic [IW-1:0] sel, sel_nxt;        // index of the currently granted lane
   logic [N-1:0]  gnt_nxt, ack_nxt;
   logic [W-1:0]  q_nxt;
   logic [IW-1:0] owner_nxt;
   logic [IW-1:0] pick;                // rotating-priority winner of req
   logic          found;

   assign busy = (state != IDLE);

   // Rotating priority scan: lowest offset from ptr (modulo N) wins.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         int idx;
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx]) begin
            pick  = idx[IW-1:0];
            found = 1'b1;
         end
      end
   end

   // Next-state and next-output logic for the IDLE/GRANT/WRITE sequencer.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sel_nxt   = sel;
      gnt_nxt   = gnt;
      ack_nxt   = ack;
      q_nxt     = Q;
      owner_nxt = owner;
      case (state)
         IDLE: begin
            ack_nxt = '0;
            gnt_nxt = '0;
            if (found) begin
               gnt_nxt[pick] = 1'b1;
               sel_nxt       = pick;
               state_nxt     = GRANT;
            end
         end
         GRANT: begin
            if (req[sel]) begin
               q_nxt        = wdata[int'(sel)*W +: W];
               ack_nxt      = '0;
               ack_nxt[sel] = 1'b1;
               owner_nxt    = sel;
               ptr_nxt      = (int'(sel) == N - 1) ? '0 : IW'(int'(sel) + 1);
               state_nxt    = WRITE;
            end else begin
               // Requester withdrew: abort without touching Q, ptr or owner.
               gnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         WRITE: begin
            ack_nxt   = '0;
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: begin
            ack_nxt   = '0;
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State, shared register and registered outputs; CLR clears all at once.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state <= IDLE;
         ptr   <= '0;
         sel   <= '0;
         gnt   <= '0;
         ack   <= '0;
         Q     <= '0;
         owner <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         sel   <= sel_nxt;
         gnt   <= gnt_nxt;
         ack   <= ack_nxt;
         Q     <= q_nxt;
         owner <= owner_nxt;
      end
   end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Testbench for reg_share_arbiter: directed scenarios with constant
// expectations, then randomized traffic against a transaction-level model.
module tb_reg_share_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = $clog2(N);

   logic           CLK = 1'b0;
   logic           CLR = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] wdata = '0;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic [W-1:0]   Q;
   logic           busy;
   logic [IW-1:0]  owner;

   int vectors = 0;
   int errors  = 0;

   reg_share_arbiter #(.N(N), .W(W), .IW(IW)) dut (
      .CLK   (CLK),
      .CLR   (CLR),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .Q     (Q),
      .busy  (busy),
      .owner (owner)
   );

   // clock
   always #5 CLK = ~CLK;

   // one rising edge, then settle away from it
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      CLR   = 1'b1;
      req   = '0;
      wdata = '0;
      @(posedge CLK);
      @(posedge CLK);
      #1;
      CLR = 1'b0;
   endtask

   task automatic set_lane(input int i, input logic [W-1:0] v);
      wdata[i*W +: W] = v;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({gnt, ack, Q, busy, owner} !== '0) begin
         errors++;
         $display("FAIL reset_state: gnt=%b ack=%b Q=%h busy=%b owner=%0d, want all 0",
                  gnt, ack, Q, busy, owner);
      end
      // load 0x5A, then get back into GRANT
      set_lane(0, 8'h5A);
      req = 4'b0001;
      tick();
      tick();
      req = '0;
      tick();
      vectors++;
      if (Q !== 8'h5A) begin
         errors++;
         $display("FAIL reset_preload: Q=%h want 5a", Q);
      end
      req = 4'b0001;
      tick();
      vectors++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_grant: gnt=%b busy=%b want 0001 1", gnt, busy);
      end
      #2;
      CLR = 1'b1;
      #1;
      vectors++;
      if ({gnt, ack, Q, busy, owner} !== '0) begin
         errors++;
         $display("FAIL reset_async: gnt=%b ack=%b Q=%h busy=%b owner=%0d, want all 0",
                  gnt, ack, Q, busy, owner);
      end
      req = '0;
      tick();
      CLR = 1'b0;
      tick();
      vectors++;
      if (ack !== '0 || Q !== '0) begin
         errors++;
         $display("FAIL reset_lost_write: ack=%b Q=%h want 0 00", ack, Q);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      set_lane(0, 8'h3C);
      req = 4'b0001;
      tick();
      vectors++;
      if (gnt !== 4'b0001 || ack !== '0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: gnt=%b ack=%b busy=%b want 0001 0000 1", gnt, ack, busy);
      end
      tick();
      vectors++;
      if (Q !== 8'h3C || ack !== 4'b0001 || gnt !== 4'b0001 || owner !== 0) begin
         errors++;
         $display("FAIL single_write: Q=%h ack=%b gnt=%b owner=%0d want 3c 0001 0001 0",
                  Q, ack, gnt, owner);
      end
      req = '0;
      tick();
      vectors++;
      if (gnt !== '0 || ack !== '0 || busy !== 1'b0 || Q !== 8'h3C) begin
         errors++;
         $display("FAIL single_done: gnt=%b ack=%b busy=%b Q=%h want 0 0 0 3c", gnt, ack, busy, Q);
      end
   endtask

   task automatic test_round_robin();
      logic [W-1:0] lanes [N];
      int           order [5];
      lanes = '{8'h10, 8'h21, 8'h32, 8'h43};
      order = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < N; i++) set_lane(i, lanes[i]);
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (gnt !== (4'b0001 << order[i])) begin
            errors++;
            $display("FAIL rr_grant[%0d]: gnt=%b want %b", i, gnt, 4'b0001 << order[i]);
         end
         tick();
         vectors++;
         if (Q !== lanes[order[i]] || ack !== (4'b0001 << order[i]) || owner !== order[i]) begin
            errors++;
            $display("FAIL rr_write[%0d]: Q=%h ack=%b owner=%0d want %h %b %0d",
                     i, Q, ack, owner, lanes[order[i]], 4'b0001 << order[i], order[i]);
         end
         tick();
         vectors++;
         if (busy !== 1'b0 || gnt !== '0 || ack !== '0) begin
            errors++;
            $display("FAIL rr_idle[%0d]: busy=%b gnt=%b ack=%b want 0", i, busy, gnt, ack);
         end
      end
      req = '0;
   endtask

   task automatic test_priority();
      do_reset();
      set_lane(0, 8'hA0);
      set_lane(2, 8'hA2);
      req = 4'b0100;
      tick();
      tick();
      tick();
      req = 4'b0101;
      tick();
      vectors++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL prio_wrap: gnt=%b want 0001", gnt);
      end
      tick();
      tick();
      tick();
      vectors++;
      if (gnt !== 4'b0100) begin
         errors++;
         $display("FAIL prio_next: gnt=%b want 0100", gnt);
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_abort();
      do_reset();
      set_lane(0, 8'h11);
      req = 4'b0001;
      tick();
      tick();
      req = '0;
      tick();
      set_lane(1, 8'h99);
      req = 4'b0010;
      tick();
      vectors++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL abort_grant: gnt=%b want 0010", gnt);
      end
      req = '0;
      tick();
      vectors++;
      if (gnt !== '0 || ack !== '0 || busy !== 1'b0 || Q !== 8'h11 || owner !== 0) begin
         errors++;
         $display("FAIL abort_drop: gnt=%b ack=%b busy=%b Q=%h owner=%0d want 0 0 0 11 0",
                  gnt, ack, busy, Q, owner);
      end
      req = 4'b0010;
      tick();
      tick();
      vectors++;
      if (ack !== 4'b0010 || Q !== 8'h99 || owner !== 1) begin
         errors++;
         $display("FAIL abort_retry: ack=%b Q=%h owner=%0d want 0010 99 1", ack, Q, owner);
      end
      req = '0;
      tick();
   endtask

   task automatic test_isolation();
      do_reset();
      set_lane(1, 8'h77);
      req = 4'b0010;
      tick();
      set_lane(0, 8'hF0);
      set_lane(3, 8'h0F);
      tick();
      vectors++;
      if (Q !== 8'h77) begin
         errors++;
         $display("FAIL iso_write: Q=%h want 77", Q);
      end
      set_lane(1, 8'h88);
      set_lane(0, 8'h0F);
      set_lane(3, 8'hF0);
      tick();
      req = '0;
      for (int i = 0; i < 3; i++) begin
         set_lane(0, 8'($urandom));
         set_lane(3, 8'($urandom));
         tick();
      end
      vectors++;
      if (Q !== 8'h77) begin
         errors++;
         $display("FAIL iso_hold: Q=%h want 77", Q);
      end
   endtask

   // Randomized traffic checked against a transaction-level model: each
   // transaction is "pick winner, then commit or abort one edge later".
   task automatic test_random();
      int           m_ptr, m_g, m_owner, m_phase;
      logic [N-1:0] m_gnt, m_ack;
      logic [W-1:0] m_q;
      logic [N-1:0] r;
      logic [N*W-1:0] d;
      do_reset();
      m_ptr = 0; m_g = 0; m_owner = 0; m_phase = 0;
      m_gnt = '0; m_ack = '0; m_q = '0;
      for (int c = 0; c < 600; c++) begin
         r = N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 3) == 0) r = '0;
         d = {$urandom, $urandom};
         req   = r;
         wdata = d[N*W-1:0];
         tick();
         // model reacts to what was sampled on this edge
         if (m_phase == 0) begin
            m_ack = '0;
            m_gnt = '0;
            if (r != '0) begin
               for (int k = 0; k < N; k++) begin
                  if (r[(m_ptr + k) % N]) begin
                     m_g = (m_ptr + k) % N;
                     break;
                  end
               end
               m_gnt = N'(1) << m_g;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (r[m_g]) begin
               m_q     = d[m_g*W +: W];
               m_ack   = N'(1) << m_g;
               m_owner = m_g;
               m_ptr   = (m_g + 1) % N;
               m_phase = 2;
            end else begin
               m_gnt   = '0;
               m_phase = 0;
            end
         end else begin
            m_ack   = '0;
            m_gnt   = '0;
            m_phase = 0;
         end
         vectors++;
         if (gnt !== m_gnt || ack !== m_ack || Q !== m_q || busy !== (m_phase != 0) ||
             owner !== IW'(m_owner)) begin
            errors++;
            $display("FAIL rand[%0d]: gnt=%b ack=%b Q=%h busy=%b owner=%0d want %b %b %h %b %0d",
                     c, gnt, ack, Q, busy, owner, m_gnt, m_ack, m_q, m_phase != 0, m_owner);
         end
         vectors++;
         if (!$onehot0(gnt) || !$onehot0(ack) || ((ack & ~gnt) != '0)) begin
            errors++;
            $display("FAIL rand_inv[%0d]: gnt=%b ack=%b", c, gnt, ack);
         end
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_priority();
      test_abort();
      test_isolation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared W-bit storage register built from the team's D flip-flop cells.
- Up to N requesters compete for write access. The block grants one requester at a time, loads that requester's data into the register, acknowledges, then rotates priority.
- It sits between the requesting units and the shared register and presents the register contents on Q.

Parameters:
N, 4, number of requesters (2..8)
W, 8, width of the shared register and of each write-data lane
IW, $clog2(N), width of the owner index

Ports:
CLK  input  1  system clock; all state changes on the rising edge
CLR  input  1  reset, asynchronous, active-high
req  input  N  write request per requester; level, held until ack or withdrawn
wdata  input  N*W  write data; lane i = wdata[i*W +: W]
gnt  output  N  one-hot grant; registered
ack  output  N  one-cycle write-complete pulse to the granted requester
Q  output  W  shared register contents
busy  output  1  high in GRANT and WRITE states
owner  output  IW  index of the last requester that completed a write

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-high (CLR). Asserting CLR forces all outputs immediately, independent of CLK.
- Reset values:
  - state = IDLE, gnt = 0, ack = 0, Q = 0, busy = 0, owner = 0.
  - Priority pointer ptr = 0.
- States and transitions (IDLE, GRANT, WRITE):
  - IDLE: if req != 0, pick the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N). Call it g. Set gnt = 1<<g and go to GRANT. If req == 0, stay in IDLE with gnt = 0.
  - GRANT: gnt is held.
    - If req[g] is still high at this edge: Q <= lane g, ack[g] <= 1, owner <= g, ptr <= (g+1) mod N, go to WRITE.
    - If req[g] has dropped: abort. gnt <= 0, no write, ptr and owner unchanged, go to IDLE.
  - WRITE: ack <= 0, gnt <= 0, go to IDLE. req is ignored in this state.
- Latency:
  - req rising before edge k gives gnt high after edge k, Q updated and ack high after edge k+1, and gnt/ack low after edge k+2.
  - Minimum 3 cycles per write; a requester holding req continuously is re-eligible at the next IDLE.
- Fairness:
  - With all N requesting continuously, grants cycle 0,1,...,N-1,0.
  - Each requester waits at most N-1 other writes.
- Requests arriving during GRANT or WRITE wait for the next IDLE evaluation. Requests and data from non-granted lanes never affect Q.
- wdata is sampled only at the GRANT-to-WRITE edge. Changes at other times have no effect.
- Invariants:
  - gnt is one-hot or zero; ack is one-hot or zero.
  - ack is never asserted without the same gnt bit asserted in the same cycle.
- Reset mid-operation: CLR during GRANT or WRITE clears everything immediately. A pending write is lost and no ack is produced. The first IDLE decision after CLR deasserts uses ptr = 0.
- Q holds its value indefinitely between writes.
- When N is not a power of 2, ptr wrap is modulo N, not modulo 2^IW.

Test Plan:
- Reset: assert CLR mid-cycle with Q=0x5A in GRANT state -> immediately gnt=0, ack=0, Q=0, busy=0, owner=0, without waiting for CLK.
- Single write: req=0001, lane0=0x3C -> gnt=0001 after edge 1; Q=0x3C, ack=0001, owner=0 after edge 2; gnt=ack=0 and busy=0 after edge 3.
- Round-robin: req=1111 held, lanes=0x10,0x21,0x32,0x43 -> grant order 0,1,2,3,0; Q sequence 0x10,0x21,0x32,0x43,0x10; writes every 3 cycles.
- Pointer wrap/priority: after a write by requester 2, req=0101 -> requester 0 is skipped? No: scan starts at 3, so 0 wins (gnt=0001); next IDLE with req=0101 grants 2.
- Abort: req=0010, then drop req[1] during GRANT -> returns to IDLE, no ack, Q unchanged, owner unchanged; next req=0010 is granted normally.
- Data isolation: requester 1 granted with lane1=0x77 while lane0 and lane3 toggle every cycle and lane1 changes to 0x88 during WRITE -> Q=0x77 exactly.
